// File: rtl/sq_gen_pkg.sv
// rtl/sq_gen_pkg.sv - shared constants and helpers for the square-wave generator
package sq_gen_pkg;

  // Register select encoding on the write port
  localparam logic WR_SEL_TC   = 1'b0;
  localparam logic WR_SEL_HIGH = 1'b1;

  // Reset configuration: period 2, high 1 -> divide-by-2 at 50% duty
  localparam int DEF_TC   = 1;
  localparam int DEF_HIGH = 1;

  // Channel index width; a single channel still needs a 1-bit select
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/sq_chan.sv
// rtl/sq_chan.sv - one square-wave channel: counter, shadow/active registers, output flops
module sq_chan
  import sq_gen_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int DEFAULT_TC   = DEF_TC,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             en_i,
  output logic             sq_o,
  output logic             tick_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] tc_sh_q, tc_sh_d;
  logic [WIDTH-1:0] hi_sh_q, hi_sh_d;
  logic [WIDTH-1:0] tc_act_q, tc_act_d;
  logic [WIDTH-1:0] hi_act_q, hi_act_d;
  logic             sq_q, sq_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == tc_act_q);

  // Next-state: shadow writes, period-boundary reload of the active pair, counter and outputs
  always_comb begin
    tc_sh_d  = tc_sh_q;
    hi_sh_d  = hi_sh_q;
    cnt_d    = cnt_q;
    tc_act_d = tc_act_q;
    hi_act_d = hi_act_q;

    if (wr_en_i) begin
      if (wr_sel_i == WR_SEL_HIGH) hi_sh_d = wr_data_i;
      else                         tc_sh_d = wr_data_i;
    end

    // Active registers always load the pre-write shadow, so a write landing on
    // the wrap cycle only takes effect at the following wrap.
    if (!en_i) begin
      cnt_d    = '0;
      tc_act_d = tc_sh_q;
      hi_act_d = hi_sh_q;
    end else if (wrap) begin
      cnt_d    = '0;
      tc_act_d = tc_sh_q;
      hi_act_d = hi_sh_q;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    sq_d   = en_i & (cnt_q < hi_act_q);
    tick_d = en_i & wrap;
  end

  // State registers; reset discards any same-cycle write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      tc_sh_q  <= WIDTH'(DEFAULT_TC);
      hi_sh_q  <= WIDTH'(DEFAULT_HIGH);
      tc_act_q <= WIDTH'(DEFAULT_TC);
      hi_act_q <= WIDTH'(DEFAULT_HIGH);
      sq_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tc_sh_q  <= tc_sh_d;
      hi_sh_q  <= hi_sh_d;
      tc_act_q <= tc_act_d;
      hi_act_q <= hi_act_d;
      sq_q     <= sq_d;
      tick_q   <= tick_d;
    end
  end

  assign sq_o   = sq_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/sq_gen_multi.sv
// rtl/sq_gen_multi.sv - multi-channel programmable square-wave / clock-divider generator
module sq_gen_multi
  import sq_gen_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 16,
  parameter int DEFAULT_TC   = DEF_TC,
  parameter int DEFAULT_HIGH = DEF_HIGH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [ch_idx_w(NUM_CH)-1:0]   wr_ch,
  input  logic                          wr_sel,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [NUM_CH-1:0]             ch_en,
  output logic [NUM_CH-1:0]             sq_out,
  output logic [NUM_CH-1:0]             tick
);

  localparam int CHW = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] wr_stb;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Channel indices beyond NUM_CH-1 match no strobe, so such writes are dropped
    assign wr_stb[i] = wr_en && (wr_ch == CHW'(i));

    sq_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_TC  (DEFAULT_TC),
      .DEFAULT_HIGH(DEFAULT_HIGH)
    ) u_chan (
      .clk_i    (clk),
      .rst_i    (rst),
      .wr_en_i  (wr_stb[i]),
      .wr_sel_i (wr_sel),
      .wr_data_i(wr_data),
      .en_i     (ch_en[i]),
      .sq_o     (sq_out[i]),
      .tick_o   (tick[i])
    );
  end

endmodule

// File: tb/tb_sq_gen_multi.sv
// tb/tb_sq_gen_multi.sv - self-checking bench for sq_gen_multi against a period-level model
module tb_sq_gen_multi;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic              wr_sel;
  logic [WIDTH-1:0]  wr_data;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] sq_out;
  logic [NUM_CH-1:0] tick;

  int checks = 0;
  int errors = 0;

  // Model: position within the current period plus the programmed and in-force settings
  int unsigned m_pos   [NUM_CH];
  int unsigned m_tc    [NUM_CH];
  int unsigned m_hi    [NUM_CH];
  int unsigned m_tc_use[NUM_CH];
  int unsigned m_hi_use[NUM_CH];
  logic [NUM_CH-1:0] exp_sq;
  logic [NUM_CH-1:0] exp_tick;

  sq_gen_multi #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_sel (wr_sel),
    .wr_data(wr_data),
    .ch_en  (ch_en),
    .sq_out (sq_out),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs presented at this edge
  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_pos[i] = 0; m_tc[i] = 1; m_hi[i] = 1; m_tc_use[i] = 1; m_hi_use[i] = 1;
        exp_sq[i] = 1'b0; exp_tick[i] = 1'b0;
      end else begin
        bit last;
        last = (m_pos[i] == m_tc_use[i]);
        exp_sq[i]   = ch_en[i] && (m_pos[i] < m_hi_use[i]);
        exp_tick[i] = ch_en[i] && last;
        if (!ch_en[i] || last) begin
          m_pos[i] = 0;
          m_tc_use[i] = m_tc[i];
          m_hi_use[i] = m_hi[i];
        end else begin
          m_pos[i] = m_pos[i] + 1;
        end
        if (wr_en && wr_ch == 2'(i)) begin
          if (wr_sel) m_hi[i] = wr_data;
          else        m_tc[i] = wr_data;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    checks++;
    assert (sq_out === exp_sq) else begin
      errors++;
      $error("FAIL %s sq_out observed=%b expected=%b", tag, sq_out, exp_sq);
    end
    checks++;
    assert (tick === exp_tick) else begin
      errors++;
      $error("FAIL %s tick observed=%b expected=%b", tag, tick, exp_tick);
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic wr(input int ch, input logic sel, input int data, input string tag);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_sel = sel; wr_data = WIDTH'(data);
    step(tag);
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = 1'b0; wr_data = '0; ch_en = '0;

    // Reset state
    run(2, "reset");
    rst = 1'b0;
    run(2, "idle");

    // Defaults on channel 0: divide by 2, tick on the low cycle
    ch_en = 4'b0001;
    step("div2_first");
    checks++;
    assert (sq_out === 4'b0001 && tick === 4'b0000) else begin
      errors++;
      $error("FAIL div2_const1 observed=%b/%b expected=0001/0000", sq_out, tick);
    end
    step("div2_second");
    checks++;
    assert (sq_out === 4'b0000 && tick === 4'b0001) else begin
      errors++;
      $error("FAIL div2_const2 observed=%b/%b expected=0000/0001", sq_out, tick);
    end
    run(6, "div2");

    // Channel 1: period 10, high 3
    wr(1, 1'b0, 9, "ch1_wr_tc");
    wr(1, 1'b1, 3, "ch1_wr_hi");
    ch_en = 4'b0011;
    run(25, "ch1_10");

    // Mid-period TC change on channel 1: current period completes, then period 5
    for (int k = 0; k < 40 && m_pos[1] != 5; k++) step("ch1_seek");
    checks++;
    assert (m_pos[1] == 5) else begin
      errors++;
      $error("FAIL ch1_seek observed=%0d expected=5", m_pos[1]);
    end
    wr(1, 1'b0, 4, "ch1_wr_tc4");
    run(20, "ch1_5");

    // Channel 2: TC=3, HIGH=0 (constant low) then HIGH=0xFFFF (constant high)
    wr(2, 1'b0, 3, "ch2_wr_tc");
    wr(2, 1'b1, 0, "ch2_wr_hi0");
    ch_en = 4'b0111;
    run(12, "ch2_low");
    wr(2, 1'b1, 16'hFFFF, "ch2_wr_hiff");
    run(12, "ch2_high");

    // Channel 0: lengthen period, then change HIGH exactly on the wrap cycle
    wr(0, 1'b0, 5, "ch0_wr_tc");
    run(14, "ch0_6");
    for (int k = 0; k < 20 && m_pos[0] != m_tc_use[0]; k++) step("ch0_seek");
    wr(0, 1'b1, 4, "ch0_wr_hi_wrap");
    run(14, "ch0_duty");

    // Reset mid-period with a same-cycle write to channel 3
    ch_en = 4'b1111;
    run(3, "all_on");
    rst = 1'b1;
    wr(3, 1'b0, 7, "rst_wr");
    checks++;
    assert (sq_out === 4'b0000 && tick === 4'b0000) else begin
      errors++;
      $error("FAIL rst_outputs observed=%b/%b expected=0000/0000", sq_out, tick);
    end
    rst = 1'b0;
    run(12, "post_rst");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst   = ($urandom_range(0, 149) == 0);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = 2'($urandom);
      wr_sel = 1'($urandom);
      wr_data = ($urandom_range(0, 15) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 10));
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      step("random");
    end
    rst = 1'b0;
    wr_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sq_gen_multi.md
Name: sq_gen_multi

Overview:
- Multi-channel programmable square-wave / clock-divider generator.
- Generalises the fixed divide-by-2 counter output: each channel has its own period, its own high time (duty), an enable and a wrap tick.
- Sits between the globally buffered board-oscillator clock and the pins or logic that need derived clocks (test tones, pixel/strobe rates).
- Configured by a simple single-cycle register write port.

Parameters:
- NUM_CH, 4, number of independent channels (1..16).
- WIDTH, 16, counter / terminal-count / high-count width in bits.
- DEFAULT_TC, 1, reset terminal count; period = TC+1 clocks.
- DEFAULT_HIGH, 1, reset high count. Defaults give divide-by-2 at 50% duty.

Ports:
- clk  in  1  system clock (global-buffered oscillator).
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, single cycle.
- wr_ch  in  max(1,$clog2(NUM_CH))  target channel.
- wr_sel  in  1  0 = terminal count (TC), 1 = high count (HIGH).
- wr_data  in  WIDTH  write value.
- ch_en  in  NUM_CH  per-channel run enable, level.
- sq_out  out  NUM_CH  square-wave outputs, registered.
- tick  out  NUM_CH  one-cycle pulse per period, registered.

Behaviour:
- Per channel state:
  - cnt[WIDTH]
  - shadow tc_sh and hi_sh (the write target)
  - active tc_act and hi_act (used for counting)
- Reset, on any clk edge with rst=1:
  - cnt=0
  - tc_sh=tc_act=DEFAULT_TC, hi_sh=hi_act=DEFAULT_HIGH
  - sq_out=0, tick=0
  - Reset overrides a same-cycle write.
  - Reset mid-period simply aborts the period; no partial tick.
- Writes:
  - wr_en=1 updates the selected shadow register at the clock edge.
  - wr_ch >= NUM_CH: write ignored.
  - Writes never touch the active registers directly.
- Disabled channel (ch_en[i]=0):
  - cnt held at 0.
  - tc_act/hi_act copy the shadow values every cycle.
  - sq_out[i] and tick[i] driven 0 from the next edge.
- Enabled channel, counter sequence:
  - if cnt==tc_act: cnt<=0, and tc_act/hi_act load from the shadow registers (period-boundary update, glitch-free).
  - else: cnt<=cnt+1.
- Outputs, with 1-cycle latency from the counter state:
  - sq_out[i] <= en & (cnt < hi_act)
  - tick[i] <= en & (cnt == tc_act)
- Duty boundaries:
  - hi_act=0: constant low.
  - hi_act > tc_act: constant high; tick still pulses.
  - tc_act=0: period 1. cnt stays 0, tick is constant 1, sq_out = (hi_act != 0).
- Write and wrap in the same cycle: the active registers load the pre-write shadow value; the new value takes effect at the following wrap.
- Enable edges:
  - Rising ch_en: counting starts from cnt=0 on the next edge.
  - First sq_out/tick reflect cnt=0 one cycle after that.
- Arithmetic:
  - Unsigned compare, WIDTH bits.
  - cnt never exceeds tc_act, so no overflow path exists.
- Channel independence: channels never interact; all share clk and rst.

Decomposition:
- Package sq_gen_pkg holds:
  - WR_SEL_TC=1'b0, WR_SEL_HIGH=1'b1
  - default TC/HIGH constants
  - a function for the channel-index width
- One sub-module, sq_chan: a single channel (counter, shadow/active registers, output flops).
  - Top instantiates NUM_CH copies via generate.
  - Top decodes wr_en/wr_ch into per-channel write strobes.

Test Plan:
1. Reset, then defaults with ch_en=4'b0001 -> sq_out[0] toggles 1,0,1,0 (divide by 2); tick[0] high every 2nd cycle; sq_out[3:1] and tick[3:1] stay 0.
2. Ch1: write TC=9, HIGH=3, then enable -> sq_out[1] high 3 cycles, low 7 cycles, repeating; tick[1] once per 10 cycles, coinciding with the last low cycle.
3. Ch1 running at TC=9: write TC=4 mid-period (cnt=5) -> current period finishes at 10 cycles; next period is 5 cycles; no runt pulse.
4. Ch2: write HIGH=0, then HIGH=0xFFFF, with TC=3 -> sq_out[2] constant 0, then constant 1 after the next wrap; tick[2] every 4 cycles throughout.
5. Ch0: write HIGH in the exact wrap cycle -> old duty is kept for one full period, new duty applies the period after.
6. Assert rst mid-period with a write to ch3 in the same cycle -> all outputs 0 next cycle; ch3 registers hold defaults (write discarded); wr_ch=NUM_CH write ignored with no channel changed.
